vx_sau_sequencer: RTL and testbench

//   Controller for the systolic array datapath inside the SAU. Holds an NxN A and an NxN B operand tile,

---
 rtl/vx_sau_sequencer_pkg.sv | 27 ++
 rtl/vx_sau_sequencer_skew_feeder.sv | 36 +++
 rtl/vx_sau_sequencer.sv | 148 ++++++++++++++
 tb/tb_vx_sau_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_sau_sequencer_pkg.sv
// Shared types and helpers for the SAU sequencer and its diagonal skew feeder.
package vx_sau_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } sau_state_e;

  localparam logic LD_SEL_A = 1'b0;
  localparam logic LD_SEL_B = 1'b1;

  // Edges from the req handshake edge to the edge that raises rsp_valid.
  function automatic int sau_latency(input int n, input int extra);
    return 3 * n - 1 + extra;
  endfunction

  // Counter must span both the feed window (2N-1) and the drain window.
  function automatic int sau_cnt_width(input int n, input int extra);
    int span;
    span = (2 * n > n + extra) ? 2 * n : n + extra;
    return (span > 1) ? $clog2(span) : 1;
  endfunction

endpackage

// File: rtl/vx_sau_sequencer_skew_feeder.sv
// Combinational diagonal select: picks the skewed A-row / B-column elements
// that belong on each array lane at feed step t.
module vx_sau_sequencer_skew_feeder
  import vx_sau_sequencer_pkg::*;
#(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int CNT_W = 3
) (
  input  logic               en,
  input  logic [CNT_W-1:0]   t,
  input  logic [N*N*DW-1:0]  buf_a,
  input  logic [N*N*DW-1:0]  buf_b,
  output logic [N*DW-1:0]    lane_a,
  output logic [N*DW-1:0]    lane_b
);

  int d;

  // Lane k carries A[k][t-k] and B[t-k][k]; outside the diagonal window it is zero.
  always_comb begin
    lane_a = '0;
    lane_b = '0;
    d      = 0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        d = int'(t) - k;
        if (d >= 0 && d < N) begin
          lane_a[k*DW +: DW] = buf_a[(k*N + d)*DW +: DW];
          lane_b[k*DW +: DW] = buf_b[(d*N + k)*DW +: DW];
        end
      end
    end
  end

endmodule

// File: rtl/vx_sau_sequencer.sv
// SAU systolic array controller: holds the A/B operand tiles, streams skewed
// wavefronts into the array lanes, waits out the drain and returns the request tag.
module vx_sau_sequencer
  import vx_sau_sequencer_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int TAG_WIDTH   = 32,
  parameter int DRAIN_EXTRA = 0,
  localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             ld_valid,
  output logic                             ld_ready,
  input  logic                             ld_sel,
  input  logic [IDX_W-1:0]                 ld_row,
  input  logic [IDX_W-1:0]                 ld_col,
  input  logic [DATA_SIZE-1:0]             ld_data,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [TAG_WIDTH-1:0]             req_tag,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [TAG_WIDTH-1:0]             rsp_tag,
  output logic                             busy,
  output logic                             arr_clear,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] arr_a,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] arr_b
);

  localparam int N            = MATRIX_SIZE;
  localparam int LANES_W      = N * DATA_SIZE;
  localparam int BUF_W        = N * N * DATA_SIZE;
  localparam int DRAIN_CYCLES = N - 1 + DRAIN_EXTRA;
  localparam int CNT_W        = sau_cnt_width(N, DRAIN_EXTRA);
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(2 * N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  sau_state_e           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic [BUF_W-1:0]     buf_a_q, buf_a_d;
  logic [BUF_W-1:0]     buf_b_q, buf_b_d;
  logic [LANES_W-1:0]   arr_a_q, arr_a_d;
  logic [LANES_W-1:0]   arr_b_q, arr_b_d;

  logic ld_fire;
  logic req_fire;
  logic ld_in_range;
  int   ld_base;

  assign ld_fire     = ld_valid && (state_q == IDLE);
  assign req_fire    = req_valid && (state_q == IDLE);
  assign ld_in_range = (int'(ld_row) < N) && (int'(ld_col) < N);

  // Next-state, counter, tag capture and operand buffer writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tag_d   = tag_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    ld_base = (int'(ld_row) * N + int'(ld_col)) * DATA_SIZE;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ld_fire && ld_in_range) begin
          if (ld_sel == LD_SEL_A) begin
            buf_a_d[ld_base +: DATA_SIZE] = ld_data;
          end else if (ld_sel == LD_SEL_B) begin
            buf_b_d[ld_base +: DATA_SIZE] = ld_data;
          end
        end
        if (req_fire) begin
          state_d = CLEAR;
          tag_d   = req_tag;
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Hold the counter so an arbitrarily long stall cannot wrap it.
        cnt_d = cnt_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  // Lanes are registered from the next state so they line up with the FEED cycle.
  vx_sau_sequencer_skew_feeder #(
    .N     (N),
    .DW    (DATA_SIZE),
    .CNT_W (CNT_W)
  ) u_feeder (
    .en     (state_d == FEED),
    .t      (cnt_d),
    .buf_a  (buf_a_q),
    .buf_b  (buf_b_q),
    .lane_a (arr_a_d),
    .lane_b (arr_b_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
      arr_a_q <= '0;
      arr_b_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
      arr_a_q <= arr_a_d;
      arr_b_q <= arr_b_d;
    end
  end

  assign ld_ready  = (state_q == IDLE);
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign arr_clear = (state_q == CLEAR);
  assign rsp_valid = (state_q == DONE);
  assign rsp_tag   = tag_q;
  assign arr_a     = arr_a_q;
  assign arr_b     = arr_b_q;

endmodule

// File: tb/tb_vx_sau_sequencer.sv
// Self-checking bench for vx_sau_sequencer: an N=3 instance for the functional
// sequences and an N=4, DRAIN_EXTRA=2 instance for latency and back-to-back runs.
module tb_vx_sau_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        ld_valid, ld_ready, ld_sel;
  logic [1:0]  ld_row, ld_col;
  logic [7:0]  ld_data;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, busy, arr_clear;
  logic [31:0] req_tag, rsp_tag;
  logic [23:0] arr_a, arr_b;

  logic        ld_valid4, ld_ready4, ld_sel4;
  logic [1:0]  ld_row4, ld_col4;
  logic [7:0]  ld_data4;
  logic        req_valid4, req_ready4, rsp_valid4, rsp_ready4, busy4, arr_clear4;
  logic [31:0] req_tag4, rsp_tag4;
  logic [31:0] arr_a4, arr_b4;

  vx_sau_sequencer #(.MATRIX_SIZE(3), .DATA_SIZE(8), .TAG_WIDTH(32), .DRAIN_EXTRA(0)) dut3 (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_row(ld_row), .ld_col(ld_col),
    .ld_data(ld_data), .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .busy(busy),
    .arr_clear(arr_clear), .arr_a(arr_a), .arr_b(arr_b)
  );

  vx_sau_sequencer #(.MATRIX_SIZE(4), .DATA_SIZE(8), .TAG_WIDTH(32), .DRAIN_EXTRA(2)) dut4 (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid4), .ld_ready(ld_ready4), .ld_sel(ld_sel4), .ld_row(ld_row4), .ld_col(ld_col4),
    .ld_data(ld_data4), .req_valid(req_valid4), .req_ready(req_ready4), .req_tag(req_tag4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_tag(rsp_tag4), .busy(busy4),
    .arr_clear(arr_clear4), .arr_a(arr_a4), .arr_b(arr_b4)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] sb3[$];
  logic [31:0] sb4[$];
  int          rsp4_seen = 0;

  typedef struct {
    logic        clr;
    logic [23:0] a;
    logic [23:0] b;
    logic        rsp;
  } vec_t;
  vec_t tbl[9];

  logic [23:0] ahist[5];
  logic [23:0] bhist[5];
  int          acc;
  int          k;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input logic sel, input logic [1:0] row, input logic [1:0] col,
                            input logic [7:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_row   = row;
    ld_col   = col;
    ld_data  = data;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic apply_req(input logic [31:0] tag);
    check_output("req_ready_before_start", req_ready, 1);
    req_valid = 1'b1;
    req_tag   = tag;
    sb3.push_back(tag);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    check_output(name, busy, 0);
  endtask

  // Scoreboards: pop the expected tag whenever a completion handshake is about to fire.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb3.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rsp3_unexpected actual=%0h required=none", rsp_tag);
      end else begin
        check_output("rsp3_tag", rsp_tag, sb3.pop_front());
      end
    end
    if (!reset && rsp_valid4 && rsp_ready4) begin
      rsp4_seen++;
      if (sb4.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rsp4_unexpected actual=%0h required=none", rsp_tag4);
      end else begin
        check_output("rsp4_tag", rsp_tag4, sb4.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Expected per-edge outputs after the req edge for A=I, B=1..9 row-major.
    tbl[0] = '{1'b1, 24'h000000, 24'h000000, 1'b0};
    tbl[1] = '{1'b0, 24'h000001, 24'h000001, 1'b0};
    tbl[2] = '{1'b0, 24'h000000, 24'h000204, 1'b0};
    tbl[3] = '{1'b0, 24'h000100, 24'h030507, 1'b0};
    tbl[4] = '{1'b0, 24'h000000, 24'h060800, 1'b0};
    tbl[5] = '{1'b0, 24'h010000, 24'h090000, 1'b0};
    tbl[6] = '{1'b0, 24'h000000, 24'h000000, 1'b0};
    tbl[7] = '{1'b0, 24'h000000, 24'h000000, 1'b0};
    tbl[8] = '{1'b0, 24'h000000, 24'h000000, 1'b1};

    reset = 1'b1;
    ld_valid = 0; ld_sel = 0; ld_row = 0; ld_col = 0; ld_data = 0;
    req_valid = 0; req_tag = 0; rsp_ready = 1;
    ld_valid4 = 0; ld_sel4 = 0; ld_row4 = 0; ld_col4 = 0; ld_data4 = 0;
    req_valid4 = 0; req_tag4 = 0; rsp_ready4 = 1;
    #13 reset = 1'b0;
    step();

    // Reset-then-idle
    check_output("rst_ld_ready", ld_ready, 1);
    check_output("rst_req_ready", req_ready, 1);
    check_output("rst_busy", busy, 0);
    check_output("rst_rsp_valid", rsp_valid, 0);
    check_output("rst_rsp_tag", rsp_tag, 0);
    check_output("rst_arr_clear", arr_clear, 0);
    check_output("rst_arr_a", arr_a, 0);
    check_output("rst_arr_b", arr_b, 0);
    check_output("rst4_busy", busy4, 0);
    check_output("rst4_req_ready", req_ready4, 1);

    // Identity run, table-driven per edge
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        apply_load(1'b0, 2'(i), 2'(j), (i == j) ? 8'd1 : 8'd0);
        apply_load(1'b1, 2'(i), 2'(j), 8'(3 * i + j + 1));
      end
    end
    apply_req(32'hA5);
    for (int n = 0; n < 9; n++) begin
      check_output($sformatf("id_clear_n%0d", n), arr_clear, tbl[n].clr);
      check_output($sformatf("id_arr_a_n%0d", n), arr_a, tbl[n].a);
      check_output($sformatf("id_arr_b_n%0d", n), arr_b, tbl[n].b);
      check_output($sformatf("id_rsp_valid_n%0d", n), rsp_valid, tbl[n].rsp);
      check_output($sformatf("id_busy_n%0d", n), busy, 1);
      if (n >= 1 && n <= 5) begin
        ahist[n-1] = arr_a;
        bhist[n-1] = arr_b;
      end
      step();
    end
    check_output("id_back_idle_req_ready", req_ready, 1);
    check_output("id_back_idle_busy", busy, 0);
    // Output-stationary array: PE(i,j) sees A[i][p] and B[p][j] together.
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        acc = 0;
        for (int p = 0; p < 3; p++) begin
          acc += int'(ahist[i+p][8*i +: 8]) * int'(bhist[j+p][8*j +: 8]);
        end
        check_output($sformatf("id_result_c%0d%0d", i, j), acc, 3 * i + j + 1);
      end
    end

    // Backpressure on the completion
    rsp_ready = 1'b0;
    apply_req(32'h3C);
    k = 0;
    while (!rsp_valid && k < 20) begin
      step();
      k++;
    end
    check_output("bp_latency", k, 8);
    for (int i = 0; i < 5; i++) begin
      check_output("bp_rsp_valid_held", rsp_valid, 1);
      check_output("bp_rsp_tag_held", rsp_tag, 32'h3C);
      check_output("bp_req_ready_low", req_ready, 0);
      check_output("bp_arr_a_zero", arr_a, 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    check_output("bp_idle_busy", busy, 0);
    check_output("bp_idle_req_ready", req_ready, 1);

    // Same-cycle load and request, then loads ignored while busy
    ld_valid = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 8'd7;
    req_valid = 1'b1; req_tag = 32'h44;
    sb3.push_back(32'h44);
    step();
    ld_valid = 1'b0; req_valid = 1'b0;
    step();
    check_output("same_cycle_lane0", arr_a[7:0], 8'd7);
    check_output("same_cycle_arr_a", arr_a, 24'h000007);
    ld_valid = 1'b1; ld_data = 8'h55;
    check_output("feed_ld_ready_low", ld_ready, 0);
    step();
    ld_valid = 1'b0;
    wait_idle(20, "same_cycle_done");
    apply_req(32'h45);
    step();
    check_output("feed_ld_dropped", arr_a, 24'h000007);
    wait_idle(20, "rerun_done");

    // Reset during FEED at t=2
    apply_req(32'h99);
    step(); step(); step();
    check_output("pre_rst_arr_a", arr_a, 24'h000100);
    check_output("pre_rst_arr_b", arr_b, 24'h030507);
    #2 reset = 1'b1;
    #1;
    check_output("async_rst_arr_a", arr_a, 0);
    check_output("async_rst_arr_b", arr_b, 0);
    check_output("async_rst_busy", busy, 0);
    check_output("async_rst_rsp_valid", rsp_valid, 0);
    sb3.delete();
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("post_rst_no_rsp", rsp_valid, 0);
    end
    apply_req(32'h77);
    check_output("post_rst_clear", arr_clear, 1);
    for (int t = 0; t < 5; t++) begin
      step();
      check_output($sformatf("post_rst_a_t%0d", t), arr_a, 0);
      check_output($sformatf("post_rst_b_t%0d", t), arr_b, 0);
    end
    wait_idle(20, "post_rst_done");

    // N=4, DRAIN_EXTRA=2: latency and back-to-back runs
    for (int r = 0; r < 3; r++) begin
      check_output("b2b_req_ready", req_ready4, 1);
      req_valid4 = 1'b1;
      req_tag4   = 32'h100 + 32'(r);
      sb4.push_back(req_tag4);
      step();
      req_valid4 = 1'b0;
      k = 0;
      while (!rsp_valid4 && k < 30) begin
        step();
        k++;
      end
      check_output($sformatf("b2b_latency_r%0d", r), k, 13);
      check_output("b2b_done_arr_a_zero", arr_a4, 0);
      step();
    end
    check_output("b2b_rsp_count", rsp4_seen, 3);
    check_output("b2b_sb4_empty", sb4.size(), 0);
    check_output("sb3_empty", sb3.size(), 0);
    check_output("b2b_idle", busy4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
